// File: rtl/sram_arb_pkg.sv
// Shared constants and types for the single-port SRAM arbiter.
// Sized for the largest supported requester count.
package sram_arb_pkg;

  localparam int NUM_REQ_MAX     = 4;
  localparam int PTR_W           = $clog2(NUM_REQ_MAX);
  localparam int SLOT_DATA_W_MAX = 32;

  typedef struct packed {
    logic                       valid;
    logic [SLOT_DATA_W_MAX-1:0] data;
  } rsp_slot_t;

  typedef struct packed {
    logic             vld;
    logic [PTR_W-1:0] id;
  } inflight_t;

  // Round-robin successor of requester g among n requesters.
  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] g, input int n);
    return (int'(g) == n - 1) ? '0 : g + 1'b1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first eligible requester at or after ptr,
// wrapping around to the lower indices.
module rr_arbiter
  import sram_arb_pkg::*;
#(
  parameter int N = 2
) (
  input  logic [N-1:0]     elig,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [PTR_W-1:0] gnt_idx
);

  always_comb begin
    logic found;
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!found && elig[i] && (i >= int'(ptr))) begin
        found   = 1'b1;
        gnt[i]  = 1'b1;
        gnt_idx = PTR_W'(i);
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!found && elig[i] && (i < int'(ptr))) begin
        found   = 1'b1;
        gnt[i]  = 1'b1;
        gnt_idx = PTR_W'(i);
      end
    end
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one single-port SRAM between NUM_REQ requesters with round-robin
// arbitration and a one-entry, back-pressurable read-response slot per requester.
module sram_port_arbiter
  import sram_arb_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ-1:0]            req_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_din,
  output logic [NUM_REQ-1:0]            rsp_valid,
  input  logic [NUM_REQ-1:0]            rsp_ready,
  output logic [NUM_REQ*DATA_WIDTH-1:0] rsp_data,
  output logic                          sram_we,
  output logic [ADDR_WIDTH-1:0]         sram_addr,
  output logic [DATA_WIDTH-1:0]         sram_din,
  input  logic [DATA_WIDTH-1:0]         sram_dout
);

  logic [NUM_REQ-1:0]    elig;
  logic [NUM_REQ-1:0]    gnt;
  logic [PTR_W-1:0]      gnt_idx;
  logic                  any_gnt;
  logic                  gnt_we;
  logic [ADDR_WIDTH-1:0] gnt_addr;
  logic [DATA_WIDTH-1:0] gnt_din;

  logic [PTR_W-1:0]      ptr_q, ptr_d;
  inflight_t             rd_q, rd_d;
  logic [ADDR_WIDTH-1:0] addr_q;

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
      logic                  rd_busy;
      logic                  capture;
      logic                  valid_q, valid_d;
      logic [DATA_WIDTH-1:0] data_q, data_d;

      assign rd_busy = rd_q.vld && (rd_q.id == PTR_W'(gi));
      assign capture = rd_busy;

      // Reads need a free (or draining) slot and nothing already in flight.
      assign elig[gi] = !rst && req_valid[gi] &&
                        (req_we[gi] || (!rd_busy && (!valid_q || rsp_ready[gi])));

      always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (valid_q && rsp_ready[gi]) begin
          valid_d = 1'b0;
        end
        if (capture) begin
          valid_d = 1'b1;
          data_d  = sram_dout;
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          valid_q <= 1'b0;
          data_q  <= '0;
        end else begin
          valid_q <= valid_d;
          data_q  <= data_d;
        end
      end

      assign rsp_valid[gi]                           = valid_q;
      assign rsp_data[gi*DATA_WIDTH +: DATA_WIDTH]   = data_q;
    end
  endgenerate

  rr_arbiter #(
    .N (NUM_REQ)
  ) u_rr (
    .elig    (elig),
    .ptr     (ptr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  always_comb begin
    gnt_addr = '0;
    gnt_din  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      gnt_addr = gnt_addr | ({ADDR_WIDTH{gnt[i]}} & req_addr[i*ADDR_WIDTH +: ADDR_WIDTH]);
      gnt_din  = gnt_din  | ({DATA_WIDTH{gnt[i]}} & req_din[i*DATA_WIDTH +: DATA_WIDTH]);
    end
  end

  assign any_gnt   = |gnt;
  assign gnt_we    = |(gnt & req_we);
  assign req_ready = gnt;
  assign sram_we   = gnt_we;
  assign sram_din  = gnt_din;
  assign sram_addr = rst ? '0 : (any_gnt ? gnt_addr : addr_q);

  // A write clears the in-flight flag so the undefined post-write dout is never captured.
  always_comb begin
    ptr_d     = any_gnt ? ptr_next(gnt_idx, NUM_REQ) : ptr_q;
    rd_d.vld  = any_gnt && !gnt_we;
    rd_d.id   = gnt_idx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q  <= '0;
      rd_q   <= '0;
      addr_q <= '0;
    end else begin
      ptr_q  <= ptr_d;
      rd_q   <= rd_d;
      addr_q <= sram_addr;
    end
  end

endmodule
